hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit feeding the HiLo register stage.
//  - Accepts an op from EX, computes a 64-bit {Hi,Lo} result over multiple cycles.
//  - Presents the result with a one-cycle write-enable pulse; these drive the HiLo register's 64-bit input and enable.
//  - Busy drives the hazard unit to stall instructions that depend on HiLo.
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH bits ({Hi,Lo})
// PORTS
//  Clk        in   1        system clock; all state updates on posedge
//  Reset      in   1        synchronous, active-high reset
//  Start      in   1        request; sampled only in IDLE
//  Op         in   3        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//  A          in   WIDTH    rs operand (multiplicand / dividend)
//  B          in   WIDTH    rt operand (multiplier / divisor)
//  HiLoCur    in   2*WIDTH  current {Hi,Lo}; accumulate base for MADD/MSUB
//  HiLoOut    out  2*WIDTH  result {Hi,Lo}; registered; holds last result
//  HiLoWrEn   out  1        1-cycle pulse: HiLoOut valid, write HiLo
//  Busy       out  1        operation in progress
//  DivByZero  out  1        registered with HiLoWrEn for DIV/DIVU with B==0
// BEHAVIOUR
//  Reset: state IDLE; all datapath regs cleared.
//   Outputs on reset: HiLoOut=0, HiLoWrEn=0, Busy=0, DivByZero=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE
//   - On Start with legal Op: latch Op, A, B, HiLoCur.
//   - Convert signed ops (MULT/DIV/MADD/MSUB) to magnitudes; record signs; clear counter.
//   - Next state CALC, except DIV/DIVU with B==0 -> FIX.
//   - Illegal Op (110, 111) with Start: ignored; no write, no Busy.
//  - CALC: one radix-2 step per cycle, counter 0..WIDTH-1; leave after exactly WIDTH cycles.
//   - Mult: shift-add of magnitudes into 2*WIDTH product.
//   - Div: restoring shift-subtract; quotient and remainder magnitudes.
//  - FIX (1 cycle): sign-correct and form the result.
//   - MULT: product negated if sign(A)!=sign(B).
//   - DIV: quotient negated if signs differ; remainder takes sign of A.
//   - {Hi,Lo} = {remainder, quotient}.
//   - MADD: HiLoCur + signed product. MSUB: HiLoCur - signed product. Modulo 2^64, no overflow flag.
//   - Divide by zero: Hi=A, Lo=all ones, DivByZero=1.
//  - DONE (1 cycle): HiLoOut loaded, HiLoWrEn=1. Next cycle back to IDLE.
//  Busy: 1 in CALC, FIX and DONE; 0 in IDLE.
//  Latency: Start sampled at edge N.
//   - Normal ops: HiLoWrEn high in cycle N+WIDTH+2 (34 for WIDTH=32).
//   - Divide by zero: HiLoWrEn high in cycle N+2.
//  Back-to-back: a new Start is accepted in the cycle after DONE (IDLE). Start while Busy is ignored, not queued.
//  Operand inputs may change after the Start cycle; only latched copies are used.
//  Wrap case: DIV of 0x80000000 by 0xFFFFFFFF gives Lo=0x80000000, Hi=0; no trap.
//  Reset mid-operation: abort to IDLE next edge; no HiLoWrEn pulse; HiLoOut cleared to 0.
//  HiLoWrEn and DivByZero are never high outside DONE.
// TESTING
//  1 MULT A=0xFFFFFFFD(-3), B=5
//    -> HiLoWrEn exactly once, 34 cycles after Start; HiLoOut=0xFFFFFFFF_FFFFFFF1
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> HiLoOut=0xFFFFFFFE_00000001
//    DIVU 100/7 -> Hi=2, Lo=14
//  3 DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF
//    DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0
//  4 DIVU A=0x1234, B=0
//    -> 2 cycles later HiLoWrEn=1, DivByZero=1, Hi=0x1234, Lo=0xFFFFFFFF
//  5 MADD HiLoCur=0x00000000_00000010, A=-2, B=3 -> 0x00000000_0000000A
//    MSUB same inputs -> 0x00000000_00000016
//  6 Control edges
//    - Start pulsed again at cycle 5 of a MULT: ignored; single write.
//    - Reset at cycle 10: Busy=0 and HiLoOut=0 next cycle; no write pulse.
//    - New op accepted on the first cycle after DONE.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing a 2*WIDTH-bit {Hi,Lo} result.
// Signed operands are reduced to magnitudes up front and sign-corrected in a single fix-up cycle.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2*WIDTH-1:0]   hiLoCur_i,
    output logic [2*WIDTH-1:0]   hiLoOut_o,
    output logic                 hiLoWrEn_o,
    output logic                 busy_o,
    output logic                 divByZero_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     aRaw_q, aRaw_d;
    logic [WIDTH-1:0]     bMag_q, bMag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   cur_q, cur_d;
    logic [2*WIDTH-1:0]   hiLoOut_q, hiLoOut_d;
    logic                 signA_q, signA_d;
    logic                 neg_q, neg_d;
    logic                 dbz_q, dbz_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 opSigned;
    logic                 isDiv;
    logic [WIDTH-1:0]     aMag;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       remShift;
    logic [WIDTH:0]       remDiff;
    logic [2*WIDTH-1:0]   prodS;
    logic [WIDTH-1:0]     quotS;
    logic [WIDTH-1:0]     remS;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aRaw_d    = aRaw_q;
        bMag_d    = bMag_q;
        acc_d     = acc_q;
        cur_d     = cur_q;
        hiLoOut_d = hiLoOut_q;
        signA_d   = signA_q;
        neg_d     = neg_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;

        opSigned = (op_i == OP_MULT) || (op_i == OP_DIV) || (op_i == OP_MADD) || (op_i == OP_MSUB);
        isDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        aMag     = (opSigned && a_i[WIDTH-1]) ? -a_i : a_i;

        // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bMag_q} : '0);
        remShift = acc_q[2*WIDTH-1:WIDTH-1];
        remDiff  = remShift - {1'b0, bMag_q};

        prodS = neg_q ? -acc_q : acc_q;
        quotS = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remS  = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (start_i && (op_i <= OP_MSUB)) begin
                    op_d    = op_i;
                    aRaw_d  = a_i;
                    bMag_d  = (opSigned && b_i[WIDTH-1]) ? -b_i : b_i;
                    acc_d   = {{WIDTH{1'b0}}, aMag};
                    cur_d   = hiLoCur_i;
                    signA_d = opSigned && a_i[WIDTH-1];
                    neg_d   = opSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    cnt_d   = '0;
                    dbz_d   = ((op_i == OP_DIV) || (op_i == OP_DIVU)) && (b_i == '0);
                    state_d = dbz_d ? FIX : CALC;
                end
            end
            CALC: begin
                if (isDiv) begin
                    if (!remDiff[WIDTH]) begin
                        acc_d = {remDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mulSum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    hiLoOut_d = {aRaw_q, {WIDTH{1'b1}}};
                end else begin
                    case (op_q)
                        OP_DIV, OP_DIVU: hiLoOut_d = {remS, quotS};
                        OP_MADD:         hiLoOut_d = cur_q + prodS;
                        OP_MSUB:         hiLoOut_d = cur_q - prodS;
                        default:         hiLoOut_d = prodS;
                    endcase
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            aRaw_q    <= '0;
            bMag_q    <= '0;
            acc_q     <= '0;
            cur_q     <= '0;
            hiLoOut_q <= '0;
            signA_q   <= 1'b0;
            neg_q     <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            aRaw_q    <= aRaw_d;
            bMag_q    <= bMag_d;
            acc_q     <= acc_d;
            cur_q     <= cur_d;
            hiLoOut_q <= hiLoOut_d;
            signA_q   <= signA_d;
            neg_q     <= neg_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hiLoOut_o   = hiLoOut_q;
    assign hiLoWrEn_o  = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign divByZero_o = (state_q == DONE) && dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit, checked against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  opIn;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic [63:0] curIn;
    logic [63:0] hiLoOut;
    logic        hiLoWrEn;
    logic        busy;
    logic        divByZero;

    int checkCount = 0;
    int passCount  = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .op_i        (opIn),
        .a_i         (aIn),
        .b_i         (bIn),
        .hiLoCur_i   (curIn),
        .hiLoOut_o   (hiLoOut),
        .hiLoWrEn_o  (hiLoWrEn),
        .busy_o      (busy),
        .divByZero_o (divByZero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end
    endtask

    // Plain signed/unsigned 64-bit arithmetic; SV division truncates and % follows the dividend sign
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] cur, output logic dbz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        dbz = 1'b0;
        res = '0;
        case (op)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    dbz = 1'b1;
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd2) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            3'd4: res = cur + (sa * sb);
            3'd5: res = cur - (sa * sb);
            default: res = '0;
        endcase
        return res;
    endfunction

    // Entered #1 after a posedge with the DUT idle; returns #1 after the edge following DONE
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] cur, input bit restartAt5, input string tag);
        logic [63:0] expOut;
        logic        expDbz;
        logic [63:0] gotOut;
        logic        gotDbz;
        int          pulses;
        int          lat;
        expOut = refModel(op, a, b, cur, expDbz);
        start  = 1'b1;
        opIn   = op;
        aIn    = a;
        bIn    = b;
        curIn  = cur;
        @(posedge clk);
        #1;
        start = 1'b0;
        aIn   = $urandom;
        bIn   = $urandom;
        curIn = {$urandom, $urandom};
        checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
        pulses = 0;
        lat    = 0;
        gotOut = '0;
        gotDbz = 1'b0;
        for (int i = 1; i <= 40 && pulses == 0; i++) begin
            if (restartAt5 && i == 5) begin
                start = 1'b1;
                opIn  = 3'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hiLoWrEn) begin
                pulses++;
                lat    = i + 1;
                gotOut = hiLoOut;
                gotDbz = divByZero;
            end
        end
        checkOutput({tag, " write pulse seen"}, 64'(pulses), 64'd1);
        checkOutput({tag, " latency"}, 64'(lat), expDbz ? 64'd2 : 64'd34);
        checkOutput({tag, " result"}, gotOut, expOut);
        checkOutput({tag, " divByZero"}, 64'(gotDbz), 64'(expDbz));
        @(posedge clk);
        #1;
        checkOutput({tag, " wrEn drops"}, 64'(hiLoWrEn), 64'd0);
        checkOutput({tag, " idle after done"}, 64'(busy), 64'd0);
        checkOutput({tag, " result holds"}, hiLoOut, expOut);
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int          pulses;
        reset = 1'b1;
        start = 1'b0;
        opIn  = '0;
        aIn   = '0;
        bIn   = '0;
        curIn = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset hiLoOut", hiLoOut, 64'd0);
        checkOutput("reset wrEn", 64'(hiLoWrEn), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset divByZero", 64'(divByZero), 64'd0);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 1'b0, "mult -3*5");
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, "multu max");
        applyStimulus(3'd3, 32'd100, 32'd7, 64'd0, 1'b0, "divu 100/7");
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0, "div -7/2");
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b0, "div wrap");
        applyStimulus(3'd3, 32'h0000_1234, 32'd0, 64'd0, 1'b0, "divu by zero");
        applyStimulus(3'd2, 32'hDEAD_BEEF, 32'd0, 64'd0, 1'b0, "div by zero");
        applyStimulus(3'd4, 32'hFFFF_FFFE, 32'd3, 64'h10, 1'b0, "madd");
        applyStimulus(3'd5, 32'hFFFF_FFFE, 32'd3, 64'h10, 1'b0, "msub");
        applyStimulus(3'd0, 32'h0001_2345, 32'hFFFF_8000, 64'd0, 1'b1, "mult restart ignored");

        for (int n = 0; n < 40; n++) begin
            rOp = 3'($urandom_range(0, 5));
            rA  = $urandom;
            case ($urandom_range(0, 3))
                0: rB = 32'($urandom_range(0, 9));
                1: rB = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, rA, rB, {$urandom, $urandom}, 1'b0, $sformatf("random %0d op%0d", n, rOp));
        end

        for (int k = 6; k <= 7; k++) begin
            start = 1'b1;
            opIn  = 3'(k);
            @(posedge clk);
            #1;
            start  = 1'b0;
            pulses = 0;
            checkOutput($sformatf("illegal op%0d busy", k), 64'(busy), 64'd0);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                if (hiLoWrEn) pulses++;
            end
            checkOutput($sformatf("illegal op%0d no write", k), 64'(pulses), 64'd0);
        end

        start = 1'b1;
        opIn  = 3'd0;
        aIn   = 32'h0000_0777;
        bIn   = 32'h0000_0555;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midop reset busy", 64'(busy), 64'd0);
        checkOutput("midop reset hiLoOut", hiLoOut, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (hiLoWrEn) pulses++;
        end
        checkOutput("midop reset no write", 64'(pulses), 64'd0);

        applyStimulus(3'd1, 32'd12345, 32'd678, 64'd0, 1'b0, "after reset");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
